// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: RAM, fixed wait states, pipeline stall, done pulse.
// Optional build macro ACCESS_COUNT_EN adds saturating load/store completion counters.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              mem_stall,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state;
  logic [3:0]         wait_cnt;
  logic               lat_store;
  logic [IDX_W-1:0]   lat_idx;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               req;
  logic               accept;
  logic               commit;
  logic               commit_store;
  logic [IDX_W-1:0]   in_idx;
  logic [IDX_W-1:0]   commit_idx;
  logic [DATA_W-1:0]  commit_wdata;

  // With zero wait states the accept edge is also the commit edge, so the
  // live request is used; otherwise the values latched at accept are used.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req          = read | write;
    accept       = (state == S_IDLE) && req;
    in_idx       = IDX_W'(addr % DEPTH);
    commit       = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (wait_cnt == 4'd0));
    commit_store = lat_store;
    commit_idx   = lat_idx;
    commit_wdata = lat_wdata;
    if (state == S_IDLE) begin
      commit_store = write;
      commit_idx   = in_idx;
      commit_wdata = wdata;
    end
  end

  assign mem_stall = accept || (state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      rdata     <= '0;
      done      <= 1'b0;
      lat_store <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_store <= write;
            lat_idx   <= in_idx;
            lat_wdata <= wdata;
            wait_cnt  <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_DONE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        done <= 1'b1;
        if (!commit_store) rdata <= mem[commit_idx];
      end
    end
  end

  // NOTE: the RAM array is deliberately not reset; only the write is gated by reset.
  always_ff @(posedge clk) begin
    if (reset && commit && commit_store) mem[commit_idx] <= commit_wdata;
  end

`ifdef ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else if (commit) begin
      if (commit_store) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 has 2 wait states / 256 words,
// instance 1 has 0 wait states / 16 words.
module tb_dmem_responder;

  logic        clk;
  logic        reset     [2];
  logic        read      [2];
  logic        write     [2];
  logic [7:0]  addr      [2];
  logic [7:0]  wdata     [2];
  logic [7:0]  rdata     [2];
  logic        done      [2];
  logic        mem_stall [2];
  logic [15:0] rd_count  [2];
  logic [15:0] wr_count  [2];

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset[0]), .read(read[0]), .write(write[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .done(done[0]), .mem_stall(mem_stall[0]),
    .rd_count(rd_count[0]), .wr_count(wr_count[0])
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset[1]), .read(read[1]), .write(write[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .done(done[1]), .mem_stall(mem_stall[1]),
    .rd_count(rd_count[1]), .wr_count(wr_count[1])
  );

  typedef struct {
    int         which;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  logic [7:0] model_mem [2][256];
  logic [7:0] last_rd   [2];
  int         n_rd      [2];
  int         n_wr      [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef ACCESS_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i] === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_done_%0d", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_instance", i, e.which);
          check($sformatf("rdata_%0d", i), {24'd0, rdata[i]}, {24'd0, e.data});
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that ends DONE.
  task automatic access(input int w_i, input logic r, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
    int   wc;
    int   dep;
    int   idx;
    int   lat;
    int   stalls;
    bit   seen;
    exp_t e;
    wc  = (w_i == 0) ? 2 : 0;
    dep = (w_i == 0) ? 256 : 16;
    idx = a % dep;
    e.which = w_i;
    if (wr) begin
      model_mem[w_i][idx] = d;
      e.data = last_rd[w_i];
      n_wr[w_i]++;
    end else begin
      e.data = model_mem[w_i][idx];
      last_rd[w_i] = e.data;
      n_rd[w_i]++;
    end
    sb.push_back(e);
    read[w_i]  = r;
    write[w_i] = wr;
    addr[w_i]  = a;
    wdata[w_i] = d;
    seen = 1'b0;
    lat = 0;
    stalls = 0;
    for (int k = 0; k < 32 && !seen; k++) begin
      @(negedge clk);
      if (done[w_i] === 1'b1) begin
        seen = 1'b1;
        lat = k;
        check("stall_in_done", {31'd0, mem_stall[w_i]}, 32'd0);
      end else if (mem_stall[w_i] === 1'b1) begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        addr[w_i]  = ~a;
        wdata[w_i] = ~d;
      end
    end
    read[w_i]  = 1'b0;
    write[w_i] = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, wc + 1);
    check("stall_cycles", stalls, wc + 1);
  endtask

  // Starts a store and pulses reset after 'hold' edges; the store must vanish.
  task automatic abort_store(input int w_i, input logic [7:0] a, input logic [7:0] d, input int hold);
    bit seen;
    write[w_i] = 1'b1;
    addr[w_i]  = a;
    wdata[w_i] = d;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    reset[w_i] = 1'b0;
    @(posedge clk);
    #1;
    reset[w_i] = 1'b1;
    write[w_i] = 1'b0;
    last_rd[w_i] = 8'h00;
    n_rd[w_i] = 0;
    n_wr[w_i] = 0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done[w_i] === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    check("abort_rdata", {24'd0, rdata[w_i]}, 32'd0);
    check("abort_stall", {31'd0, mem_stall[w_i]}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0;
      read[i]  = 1'b0;
      write[i] = 1'b0;
      addr[i]  = 8'h00;
      wdata[i] = 8'h00;
      last_rd[i] = 8'h00;
      n_rd[i] = 0;
      n_wr[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_rdata", {24'd0, rdata[i]}, 32'd0);
      check("reset_done", {31'd0, done[i]}, 32'd0);
      check("reset_stall", {31'd0, mem_stall[i]}, 32'd0);
      check("reset_rd_count", {16'd0, rd_count[i]}, 32'd0);
      check("reset_wr_count", {16'd0, wr_count[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    @(posedge clk);
    #1;

    // Two wait states: basic store/load, read+write as store, abort on reset.
    access(0, 1'b0, 1'b1, 8'h10, 8'hA5);
    access(0, 1'b1, 1'b0, 8'h10, 8'h00);
    access(0, 1'b1, 1'b1, 8'h20, 8'h5A);
    access(0, 1'b1, 1'b0, 8'h20, 8'h00);
    access(0, 1'b0, 1'b1, 8'h40, 8'h77);
    abort_store(0, 8'h40, 8'hFF, 1);
    abort_store(0, 8'h40, 8'hFF, 2);
    access(0, 1'b1, 1'b0, 8'h40, 8'h00);
    access(0, 1'b1, 1'b0, 8'h10, 8'h00);
    access(0, 1'b1, 1'b0, 8'h20, 8'h00);
    access(0, 1'b0, 1'b1, 8'h30, 8'h11);
    access(0, 1'b0, 1'b1, 8'h31, 8'h22);

    // Zero wait states, 16 words: back-to-back accesses and address wrap.
    access(1, 1'b0, 1'b1, 8'h3C, 8'hC3);
    access(1, 1'b1, 1'b0, 8'h3C, 8'h00);
    access(1, 1'b0, 1'b1, 8'h12, 8'hE1);
    access(1, 1'b1, 1'b0, 8'h02, 8'h00);
    access(1, 1'b1, 1'b1, 8'h05, 8'h99);
    access(1, 1'b1, 1'b0, 8'h05, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rd_count", {16'd0, rd_count[i]}, exp_cnt(n_rd[i]));
      check("wr_count", {16'd0, wr_count[i]}, exp_cnt(n_wr[i]));
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
